// File: rtl/chan_cfg_bank.sv
// rtl/chan_cfg_bank.sv - shadowed channel-configuration store with atomic commit sequencer
// Optional checksum gate on commit: define CFG_CHECKSUM_EN.
module chan_cfg_bank #(
  parameter int N_CH   = 16,
  parameter int PL_W   = 17,
  parameter int MULT_W = 5,
  parameter int TYPE_W = 4,
  parameter int AW     = 8
) (
  input  logic                     clk_RAM,
  input  logic                     rst,
  input  logic [7:0]               in,
  input  logic [AW-1:0]            w_addr,
  input  logic                     write,
  input  logic                     commit,
  input  logic [AW-1:0]            rd_addr,
  output logic [7:0]               rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [N_CH*PL_W-1:0]     pl_drt,
  output logic [N_CH*PL_W-1:0]     dl_del,
  output logic [N_CH*MULT_W-1:0]   mult_pl,
  output logic [N_CH*MULT_W-1:0]   mult_dl,
  output logic [N_CH*TYPE_W-1:0]   type_start
);

`ifdef CFG_CHECKSUM_EN
  localparam int MAP_SZ = N_CH * 7 + 1;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [AW-1:0] LAST_BYTE = AW'(N_CH * 7);
`else
  localparam int MAP_SZ = N_CH * 7;
`endif
  localparam int IW = (MAP_SZ > 1) ? $clog2(MAP_SZ) : 1;
  localparam logic [AW:0] MAP_END = (AW+1)'(MAP_SZ);
  localparam logic [AW-1:0] LAST_CH = AW'(N_CH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_COPY = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [7:0]    shadow [0:MAP_SZ-1];
  logic [1:0]    state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] ch_base;
  logic [7:0]    cb [0:6];
  logic          w_in_map, rd_in_map;
  logic          wr_ok, wr_rej, cm_rej;
  logic [15:0]   pl_raw, dl_raw;
`ifdef CFG_CHECKSUM_EN
  logic [7:0]    acc;
  logic [7:0]    chk_byte;
`endif

  assign w_in_map  = ({1'b0, w_addr} < MAP_END);
  assign rd_in_map = ({1'b0, rd_addr} < MAP_END);
  assign wr_ok     = !write && !busy && w_in_map;
  assign wr_rej    = !write && (busy || !w_in_map);
  assign cm_rej    = commit && busy;
  assign ch_base   = AW'(cnt * AW'(7));
  assign pl_raw    = {cb[0], cb[1]};
  assign dl_raw    = {cb[3], cb[4]};
`ifdef CFG_CHECKSUM_EN
  assign chk_byte  = shadow[IW'(cnt)];
`endif

  // Gather the seven shadow bytes of the channel currently being copied
  always_comb begin
    for (int k = 0; k < 7; k++) begin
      cb[k] = shadow[IW'(ch_base + AW'(k))];
    end
  end

  // Shadow byte array and registered readback; writes blocked while a commit runs
  always_ff @(posedge clk_RAM) begin
    if (rst) begin
      for (int i = 0; i < MAP_SZ; i++) begin
        shadow[i] <= 8'h00;
      end
      rd_data <= 8'h00;
    end else begin
      if (wr_ok) begin
        shadow[IW'(w_addr)] <= in;
      end
      rd_data <= rd_in_map ? shadow[IW'(rd_addr)] : 8'h00;
    end
  end

  // Commit sequencer: optional checksum walk, one channel copied per clock, then done
  always_ff @(posedge clk_RAM) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      pl_drt     <= '0;
      dl_del     <= '0;
      mult_pl    <= '0;
      mult_dl    <= '0;
      type_start <= '0;
`ifdef CFG_CHECKSUM_EN
      acc        <= 8'h00;
`endif
    end else begin
      done <= 1'b0;
      err  <= wr_rej | cm_rej;
      case (state)
        S_IDLE: begin
          if (commit) begin
            busy <= 1'b1;
            cnt  <= '0;
`ifdef CFG_CHECKSUM_EN
            acc   <= 8'h00;
            state <= S_CHECK;
`else
            state <= S_COPY;
`endif
          end
        end
`ifdef CFG_CHECKSUM_EN
        S_CHECK: begin
          acc <= acc ^ chk_byte;
          if (cnt == LAST_BYTE) begin
            cnt <= '0;
            if ((acc ^ chk_byte) == 8'h00) begin
              state <= S_COPY;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        S_COPY: begin
          pl_drt[cnt*PL_W +: PL_W]       <= PL_W'(pl_raw);
          dl_del[cnt*PL_W +: PL_W]       <= PL_W'(dl_raw);
          mult_pl[cnt*MULT_W +: MULT_W]  <= MULT_W'(cb[2]);
          mult_dl[cnt*MULT_W +: MULT_W]  <= MULT_W'(cb[5]);
          type_start[cnt*TYPE_W +: TYPE_W] <= TYPE_W'(cb[6]);
          if (cnt == LAST_CH) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/chan_cfg_bank.md
Name: chan_cfg_bank

Overview:
- Parametrised channel-configuration store for the pulse generator.
- Accepts address/byte writes from the UART receive path into a shadow byte array.
- On a commit request, a sequencer transfers the shadow into active per-channel registers one channel per clock. The pulse channels therefore never see a half-written configuration.
- Adds shadow readback and write/commit status over the previous fixed 8-channel store.

Parameters:
- N_CH, 16, number of pulse channels (1..32).
- PL_W, 17, pulse-length and delay output width (9..17); upper bits zero-extended from the 16-bit byte pair.
- MULT_W, 5, multiplier field width (1..8); taken from low bits of its byte.
- TYPE_W, 4, start-type field width (1..8); taken from low bits of its byte.
- AW, 8, byte address width; must satisfy 2^AW > N_CH*7.

Ports:
- clk_RAM  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- in  in  8  write data byte.
- w_addr  in  AW  write byte address.
- write  in  1  active-low write strobe, sampled every clock.
- commit  in  1  single-cycle request to transfer shadow to active.
- rd_addr  in  AW  shadow readback address.
- rd_data  out  8  shadow byte at rd_addr, registered.
- busy  out  1  high while a commit is in progress.
- done  out  1  one-cycle pulse when a commit completes successfully.
- err  out  1  one-cycle pulse on a rejected write or rejected commit.
- pl_drt  out  N_CH*PL_W  active pulse lengths; channel c at [c*PL_W +: PL_W].
- dl_del  out  N_CH*PL_W  active delays, packed the same way.
- mult_pl  out  N_CH*MULT_W  active pulse-length multipliers.
- mult_dl  out  N_CH*MULT_W  active delay multipliers.
- type_start  out  N_CH*TYPE_W  active start types.

Behaviour:
- Memory map: channel c occupies byte base c*7:
  - +0 PL hi, +1 PL lo, +2 Mult_PL
  - +3 DL hi, +4 DL lo, +5 Mult_DL
  - +6 type
- Address N_CH*7 is the checksum byte; it exists only with the optional feature.
- Reset: shadow array, all active outputs, rd_data, busy, done, err and the FSM state go to 0 / IDLE. Reset mid-commit aborts the commit with active outputs zeroed.
- Write: when write==0, not busy, and w_addr is inside the map, the shadow byte is updated at the clock edge.
  - If w_addr is outside the map, or busy==1: no update, err pulses the next cycle.
- Readback: rd_data = shadow[rd_addr] one clock after rd_addr is presented; reads 0 out of map. A same-cycle write to rd_addr returns the old byte; the new byte appears one cycle later.
- FSM states: IDLE, CHECK (feature only), COPY, DONE.
  - IDLE: commit==1 moves to CHECK if the feature is on, else to COPY, with channel counter ch=0; busy rises the next cycle.
  - COPY: each cycle loads active channel ch from shadow bytes c*7..c*7+6, then ch increments. After ch==N_CH-1 the FSM moves to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Commit latency without the feature: busy high for exactly N_CH+1 cycles (COPY N_CH, DONE 1). Outputs of channel c change at cycle c+1 after the commit edge.
- commit while busy is ignored and pulses err.
- A write and a commit in the same IDLE cycle: the write is applied first, and that byte is included in the commit.
- Width rule: PL value = {hi,lo} zero-extended to PL_W. When PL_W<16, bits above PL_W are dropped.

Optional Feature:
- Macro: CFG_CHECKSUM_EN.
- Defined:
  - Extra shadow byte at N_CH*7.
  - The CHECK state walks bytes 0..N_CH*7 at one per cycle, XOR-accumulating into an 8-bit register.
  - If the result is 0x00, go to COPY. Otherwise pulse err, drop busy, return to IDLE, and leave active outputs untouched (no done).
  - Adds N_CH*7+1 cycles of latency.
- Undefined: no CHECK state; address N_CH*7 is out of map and writing it pulses err.

Test Plan:
- Reset: assert rst 2 cycles with write=0 and commit=1 -> all outputs 0, no shadow update, busy/done/err 0.
- Write ch0 bytes 0x01,0x2C,0x03,0x00,0x64,0x02,0x05 at 0..6, then commit:
  - pl_drt[0]=300, mult_pl=3, dl_del=100, mult_dl=2, type=5.
  - busy high N_CH+1 cycles, single done pulse.
  - Active outputs unchanged before commit.
- Write to 0x05 during busy, and write to address N_CH*7+1 -> err pulse each; readback of 0x05 shows the old value; active outputs unaffected.
- Second commit issued mid-COPY -> err pulse, single done, channel N_CH-1 updated in the last COPY cycle.
- rst asserted at COPY cycle 3 -> all outputs 0 the next cycle, FSM IDLE, no done.
- CFG_CHECKSUM_EN:
  - Bad checksum byte -> err, busy drops after N_CH*7+1 cycles, outputs held.
  - Correct checksum (XOR of all bytes) -> done after N_CH*8+2 cycles.
